// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bundle of the parametrised FIFO.
// Ports: wr_en/din/rd_en from the master; dout, data_count, status flags,
//   per-direction ack/err and the last-operation code (state) from the slave.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [2:0]            state;

  // Master: the producer/consumer driving requests into the FIFO.
  modport master (
    output wr_en, rd_en, din,
    input  dout, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err, state
  );

  // Slave: the FIFO itself.
  modport slave (
    input  wr_en, rd_en, din,
    output dout, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err, state
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: DEPTH=2**ADDR_WIDTH x DATA_WIDTH storage with count/threshold flags.
// Latency: written word readable from the next edge; dout/rd_ack valid the cycle after the accepting edge.
// Backpressure: none; a write when full raises wr_err, a read when empty raises rd_err, state is unchanged.
// Ports: clk, reset (sync, active-high); bus (fifo_param_if.slave) carries
//   wr_en/rd_en/din in and dout, data_count, full/empty, almost_full/almost_empty,
//   wr_ack/wr_err, rd_ack/rd_err and the 3-bit last-operation code out.
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic          clk,
  input  logic          reset,
  fifo_param_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101,
    RD_WR    = 3'b110
  } op_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head_q, tail_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  op_e                   state_q, state_d;
  logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic                  wr_ack_d, wr_err_d, rd_ack_d, rd_err_d;
  logic                  wr_go, rd_go;
  logic                  is_full, is_empty;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);

  // Decide the operation for this edge from the requests and the current count.
  always_comb begin
    state_d  = NO_OP;
    wr_go    = 1'b0;
    rd_go    = 1'b0;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    case ({bus.wr_en, bus.rd_en})
      2'b10: begin
        if (!is_full) begin
          state_d  = WRITE;
          wr_go    = 1'b1;
          wr_ack_d = 1'b1;
        end else begin
          state_d  = WR_ERROR;
          wr_err_d = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) begin
          state_d  = READ;
          rd_go    = 1'b1;
          rd_ack_d = 1'b1;
        end else begin
          state_d  = RD_ERROR;
          rd_err_d = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Full is fine here: the read frees the slot the write consumes.
          state_d  = RD_WR;
          wr_go    = 1'b1;
          rd_go    = 1'b1;
          wr_ack_d = 1'b1;
          rd_ack_d = 1'b1;
        end else begin
          // Empty: the write lands but din is not forwarded to dout.
          state_d  = WRITE;
          wr_go    = 1'b1;
          wr_ack_d = 1'b1;
          rd_err_d = 1'b1;
        end
      end
      default: state_d = NO_OP;
    endcase

    case ({wr_go, rd_go})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      state_q  <= INIT;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_go) tail_q <= tail_q + 1'b1;
      if (rd_go) begin
        head_q <= head_q + 1'b1;
        dout_q <= mem[head_q];
      end
      count_q  <= count_d;
      state_q  <= state_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_go && !reset) mem[tail_q] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.data_count   = count_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param at default parameters (32 x 8, AF=7, AE=1).
// A queue-based model predicts every output each cycle; directed steps add literal checks.
module tb_fifo_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] q[$];
  logic [31:0] m_dout;
  logic [2:0]  m_state;
  logic        m_wack, m_werr, m_rack, m_rerr;

  always @(posedge clk) begin
    m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
    if (reset) begin
      q.delete();
      m_dout  = 0;
      m_state = 3'd0;
    end else begin
      case ({bus.wr_en, bus.rd_en})
        2'b10: if (q.size() < 8) begin q.push_back(bus.din); m_state = 3'd2; m_wack = 1; end
               else begin m_state = 3'd3; m_werr = 1; end
        2'b01: if (q.size() > 0) begin m_dout = q.pop_front(); m_state = 3'd4; m_rack = 1; end
               else begin m_state = 3'd5; m_rerr = 1; end
        2'b11: if (q.size() > 0) begin
                 m_dout = q.pop_front(); q.push_back(bus.din);
                 m_state = 3'd6; m_wack = 1; m_rack = 1;
               end else begin
                 q.push_back(bus.din); m_state = 3'd2; m_wack = 1; m_rerr = 1;
               end
        default: m_state = 3'd1;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",   32'(bus.data_count),   32'(q.size()));
      chk("dout",    bus.dout,              m_dout);
      chk("state",   32'(bus.state),        32'(m_state));
      chk("full",    32'(bus.full),         32'(q.size() == 8));
      chk("empty",   32'(bus.empty),        32'(q.size() == 0));
      chk("afull",   32'(bus.almost_full),  32'(q.size() >= 7));
      chk("aempty",  32'(bus.almost_empty), 32'(q.size() <= 1));
      chk("wr_ack",  32'(bus.wr_ack),       32'(m_wack));
      chk("wr_err",  32'(bus.wr_err),       32'(m_werr));
      chk("rd_ack",  32'(bus.rd_ack),       32'(m_rack));
      chk("rd_err",  32'(bus.rd_err),       32'(m_rerr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.rd_en = 0; bus.din = 0;
    #1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_en = 1'b1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_count", 32'(bus.data_count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_dout",  bus.dout, 32'd0);
    reset = 1'b0;

    // idle
    step(0, 0, 0);
    chk("idle_state", 32'(bus.state), 32'd1);
    chk("idle_acks", {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 32'd0);

    // fill 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 32'h11 * i);
      chk("fill_ack", 32'(bus.wr_ack), 32'd1);
      if (i == 7) chk("afull_at7", 32'(bus.almost_full), 32'd1);
    end
    chk("fill_count", 32'(bus.data_count), 32'd8);
    chk("fill_full",  32'(bus.full), 32'd1);
    step(1, 0, 32'h99);
    chk("ovf_err",   32'(bus.wr_err), 32'd1);
    chk("ovf_state", 32'(bus.state), 32'd3);
    chk("ovf_count", 32'(bus.data_count), 32'd8);

    // drain
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0);
      chk("drain_dout", bus.dout, 32'h11 * i);
      chk("drain_ack",  32'(bus.rd_ack), 32'd1);
    end
    step(0, 1, 0);
    chk("udf_err",   32'(bus.rd_err), 32'd1);
    chk("udf_state", 32'(bus.state), 32'd5);
    chk("udf_dout",  bus.dout, 32'h88);
    chk("udf_empty", 32'(bus.empty), 32'd1);

    // simultaneous at count 3
    for (int i = 1; i <= 3; i++) step(1, 0, 32'(i));
    step(1, 1, 32'hAB);
    chk("rw3_state", 32'(bus.state), 32'd6);
    chk("rw3_count", 32'(bus.data_count), 32'd3);
    chk("rw3_dout",  bus.dout, 32'h1);
    // simultaneous at full
    for (int i = 4; i <= 8; i++) step(1, 0, 32'(i));
    step(1, 1, 32'hCD);
    chk("rw8_state", 32'(bus.state), 32'd6);
    chk("rw8_count", 32'(bus.data_count), 32'd8);
    chk("rw8_dout",  bus.dout, 32'h2);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("rw8_last", bus.dout, 32'hCD);
    // simultaneous at empty
    step(1, 1, 32'hEE);
    chk("rw0_state", 32'(bus.state), 32'd2);
    chk("rw0_rderr", 32'(bus.rd_err), 32'd1);
    chk("rw0_count", 32'(bus.data_count), 32'd1);
    step(0, 1, 0);
    chk("rw0_read", bus.dout, 32'hEE);

    // wrap-around
    for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + i);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h200 + i);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("wrap_last",  bus.dout, 32'h205);
    chk("wrap_count", 32'(bus.data_count), 32'd0);

    // reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 0, 32'h300 + i);
    reset = 1'b1;
    step(1, 0, 32'h3FF);
    reset = 1'b0;
    chk("mrst_count", 32'(bus.data_count), 32'd0);
    chk("mrst_state", 32'(bus.state), 32'd0);
    chk("mrst_wack",  32'(bus.wr_ack), 32'd0);
    step(0, 1, 0);
    chk("mrst_rderr", 32'(bus.rd_err), 32'd1);

    step(0, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
